collision_detector: RTL and testbench
=====================================

# collision_detector

Resolves each Pac-Man move request against the maze tile map and the ghost positions. For every requested move it produces a one-cycle `collision_type` code and a move accept/deny. It also erases eaten pills and power pellets from the map RAM. It sits between the movement controller and the map RAM, and is the producer of the `collision_type` bus consumed by `pill_counter` and the scoring/game-state logic.

## Interface
Parameters:
- COLS, 28, maze width in tiles
- ROWS, 31, maze height in tiles
- X_W, 5, column coordinate width
- Y_W, 5, row coordinate width
- ADDR_W, 10, map RAM address width
- N_GHOSTS, 4, number of ghost positions compared

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- move_valid  in  1  move request strobe; sampled only in IDLE
- pac_x  in  X_W  target column of the move
- pac_y  in  Y_W  target row of the move
- ghost_x  in  N_GHOSTS*X_W  packed ghost columns; ghost i occupies bits [i*X_W +: X_W]
- ghost_y  in  N_GHOSTS*Y_W  packed ghost rows
- busy  out  1  high whenever the FSM is not in IDLE
- map_rd_en  out  1  map RAM read enable
- map_addr  out  ADDR_W  map RAM address, equal to pac_y*COLS + pac_x
- map_rd_data  in  2  tile code; valid one cycle after map_rd_en
- map_wr_en  out  1  map RAM write enable
- map_wr_data  out  2  write data; always TILE_EMPTY
- collision_type  out  4  one-cycle collision code
- move_ack  out  1  one-cycle pulse, coincident with collision_type
- move_ok  out  1  move permitted; qualified by move_ack

## Operation
- Tile codes: 00 EMPTY, 01 WALL, 10 PILL, 11 POWER.
- Collision codes:
  - 4'b0000 NONE
  - 4'b0001 WALL
  - 4'b0010 PILL
  - 4'b0100 POWER
  - 4'b1000 GHOST
- FSM states: IDLE, READ, WAIT, DECIDE, CLEAR.
- IDLE:
  - On move_valid, register pac_x and pac_y, then go to READ.
  - If the target is out of range (x ≥ COLS or y ≥ ROWS), go directly to DECIDE with the tile forced to WALL; no RAM access occurs.
- READ: map_rd_en=1 and map_addr driven; go to WAIT.
- WAIT: capture map_rd_data into the tile register; go to DECIDE.
- DECIDE: drive the code for one cycle with move_ack=1. Priority is GHOST > WALL > POWER > PILL > NONE.
  - GHOST: any ghost (ghost_x, ghost_y sampled this cycle) equals the target.
  - move_ok=0 only for WALL; move_ok=1 for all other results, including GHOST.
  - Go to CLEAR if the tile is PILL or POWER and the result is not GHOST. Otherwise go to IDLE.
- CLEAR: map_wr_en=1, map_addr = the same target, map_wr_data=00; go to IDLE.
- Outside DECIDE: collision_type=0000, move_ack=0, move_ok=0.
- A ghost hit on a pill tile reports GHOST only and the pill is not erased.

## Timing
- Reset values (asynchronous, while reset is low):
  - state=IDLE
  - busy=0, map_rd_en=0, map_wr_en=0, map_addr=0, map_wr_data=00
  - collision_type=0000, move_ack=0, move_ok=0
- A reset asserted mid-operation aborts any pending write and returns the FSM to IDLE.
- Latency, with move_valid accepted in cycle 0:
  - map_rd_en high in cycle 1
  - DECIDE outputs in cycle 3
  - map_wr_en in cycle 4 when a clear is needed
  - First cycle a new request can be accepted: cycle 4 without a clear, cycle 5 with a clear.
- Out-of-range target: DECIDE outputs in cycle 1.
- move_valid while busy=1 is ignored and is not queued; the requester holds or re-issues it.
- Consecutive DECIDE pulses are at least 2 cycles apart, even on the out-of-range path. This is required because pill_counter's hold/incre FSM misses codes closer than 2 cycles apart.
- collision_type is never high for more than one consecutive cycle.

## Configuration
- GHOST_COLLIDE_EN:
  - Defined: ghost comparators are compiled in and the GHOST code is reachable.
  - Undefined: ghost_x and ghost_y are unused, GHOST is never produced, and the priority becomes WALL > POWER > PILL > NONE.

## Structure
- Shared package `pacman_pkg`:
  - tile code typedef `tile_t`, 2 bits
  - collision code constants COL_NONE, COL_WALL, COL_PILL, COL_POWER, COL_GHOST, 4 bits each
  - FSM state enum
  - `pill_counter` and scoring import the same COL_* constants.
- One sub-module: `ghost_match`, a combinational N_GHOSTS-way coordinate comparator with a single hit output. It is instantiated only under GHOST_COLLIDE_EN.

## Test plan
- Reset low, then released: all outputs 0. A move to (1,1) where the map holds PILL gives map_rd_en in cycle 1, address 29, collision_type 0010 with move_ok=1 in cycle 3, and a write of 00 to address 29 in cycle 4.
- A move to a WALL tile gives collision_type 0001, move_ok=0 and no write. A move to x=28 gives 0001 in cycle 1 with no RAM read.
- A POWER tile with ghost 2 on the same tile gives 0100 with the macro undefined. With the macro defined it gives 1000, and map_wr_en stays 0.
- Back-to-back move_valid held high over 4 pill moves: exactly 4 DECIDE pulses at least 2 cycles apart. A connected pill_counter reaches 4.
- move_valid pulsed while busy is ignored. Reset asserted during WAIT gives immediate IDLE with no map_wr_en and no pulse.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared Pac-Man types: tile codes, collision codes, and the collision FSM states.
package pacman_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'b00,
    TILE_WALL  = 2'b01,
    TILE_PILL  = 2'b10,
    TILE_POWER = 2'b11
  } tile_t;

  // One-hot collision codes, also decoded by pill_counter and the scoring logic.
  localparam logic [3:0] COL_NONE  = 4'b0000;
  localparam logic [3:0] COL_WALL  = 4'b0001;
  localparam logic [3:0] COL_PILL  = 4'b0010;
  localparam logic [3:0] COL_POWER = 4'b0100;
  localparam logic [3:0] COL_GHOST = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DECIDE,
    ST_CLEAR
  } cd_state_t;

endpackage

// File: rtl/collision_detector_ghost_match.sv
// N-way ghost coordinate comparator: hit is high when any ghost sits on the target tile.
module ghost_match #(
  parameter int N_GHOSTS = 4,
  parameter int X_W      = 5,
  parameter int Y_W      = 5
) (
  input  logic [N_GHOSTS*X_W-1:0] ghost_x,
  input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
  input  logic [X_W-1:0]          tgt_x,
  input  logic [Y_W-1:0]          tgt_y,
  output logic                    hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      if ((ghost_x[i*X_W +: X_W] == tgt_x) && (ghost_y[i*Y_W +: Y_W] == tgt_y))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Resolves Pac-Man moves against the tile map and ghosts, erasing eaten pills/pellets.
// Optional build macro GHOST_COLLIDE_EN compiles in the ghost comparators.
module collision_detector
  import pacman_pkg::*;
#(
  parameter int COLS     = 28,
  parameter int ROWS     = 31,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int ADDR_W   = 10,
  parameter int N_GHOSTS = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    move_valid,
  input  logic [X_W-1:0]          pac_x,
  input  logic [Y_W-1:0]          pac_y,
  input  logic [N_GHOSTS*X_W-1:0] ghost_x,
  input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
  output logic                    busy,
  output logic                    map_rd_en,
  output logic [ADDR_W-1:0]       map_addr,
  input  logic [1:0]              map_rd_data,
  output logic                    map_wr_en,
  output logic [1:0]              map_wr_data,
  output logic [3:0]              collision_type,
  output logic                    move_ack,
  output logic                    move_ok
);

  cd_state_t        state;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  tile_t            tile_q;
  logic             ghost_hit;
  logic             out_of_range;
  logic [ADDR_W-1:0] addr_in;
  logic [3:0]       code_next;

  function automatic logic [3:0] resolve(input tile_t tile, input logic ghost);
    logic [3:0] code;
    if (ghost)
      code = COL_GHOST;
    else begin
      case (tile)
        TILE_WALL:  code = COL_WALL;
        TILE_POWER: code = COL_POWER;
        TILE_PILL:  code = COL_PILL;
        default:    code = COL_NONE;
      endcase
    end
    return code;
  endfunction

`ifdef GHOST_COLLIDE_EN
  logic [X_W-1:0] tgt_x;
  logic [Y_W-1:0] tgt_y;

  // In IDLE the out-of-range path decides straight from the request inputs.
  assign tgt_x = (state == ST_IDLE) ? pac_x : x_q;
  assign tgt_y = (state == ST_IDLE) ? pac_y : y_q;

  ghost_match #(
    .N_GHOSTS (N_GHOSTS),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_ghost_match (
    .ghost_x (ghost_x),
    .ghost_y (ghost_y),
    .tgt_x   (tgt_x),
    .tgt_y   (tgt_y),
    .hit     (ghost_hit)
  );
`else
  logic unused_ghost;
  assign unused_ghost = ^{ghost_x, ghost_y};
  assign ghost_hit    = 1'b0;
`endif

  assign out_of_range = (int'(pac_x) >= COLS) || (int'(pac_y) >= ROWS);
  assign addr_in      = ADDR_W'(pac_y) * ADDR_W'(COLS) + ADDR_W'(pac_x);
  assign map_wr_data  = TILE_EMPTY;

  // Decision outputs are registered on the edge that enters DECIDE.
  assign code_next = resolve((state == ST_IDLE) ? TILE_WALL : tile_t'(map_rd_data), ghost_hit);

  always_ff @(posedge CLOCK_50) begin
    if (state == ST_IDLE && move_valid) begin
      x_q <= pac_x;
      y_q <= pac_y;
      if (out_of_range)
        tile_q <= TILE_WALL;
    end else if (state == ST_WAIT) begin
      tile_q <= tile_t'(map_rd_data);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      map_rd_en      <= 1'b0;
      map_wr_en      <= 1'b0;
      map_addr       <= '0;
      collision_type <= COL_NONE;
      move_ack       <= 1'b0;
      move_ok        <= 1'b0;
    end else begin
      map_rd_en      <= 1'b0;
      map_wr_en      <= 1'b0;
      collision_type <= COL_NONE;
      move_ack       <= 1'b0;
      move_ok        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (move_valid) begin
            busy <= 1'b1;
            if (out_of_range) begin
              collision_type <= code_next;
              move_ack       <= 1'b1;
              move_ok        <= (code_next != COL_WALL);
              state          <= ST_DECIDE;
            end else begin
              map_rd_en <= 1'b1;
              map_addr  <= addr_in;
              state     <= ST_READ;
            end
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          collision_type <= code_next;
          move_ack       <= 1'b1;
          move_ok        <= (code_next != COL_WALL);
          state          <= ST_DECIDE;
        end
        ST_DECIDE: begin
          // A ghost hit leaves the pill on the map.
          if ((tile_q == TILE_PILL || tile_q == TILE_POWER) && collision_type != COL_GHOST) begin
            map_wr_en <= 1'b1;
            state     <= ST_CLEAR;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector with a map RAM and a tile-level reference model.
module tb_collision_detector;

  localparam int COLS = 28;
  localparam int ROWS = 31;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        move_valid = 1'b0;
  logic [4:0]  pac_x = '0;
  logic [4:0]  pac_y = '0;
  logic [19:0] ghost_x = '1;
  logic [19:0] ghost_y = '1;
  logic        busy, map_rd_en, map_wr_en, move_ack, move_ok;
  logic [9:0]  map_addr;
  logic [1:0]  map_rd_data, map_wr_data;
  logic [3:0]  collision_type;

  collision_detector dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .move_valid     (move_valid),
    .pac_x          (pac_x),
    .pac_y          (pac_y),
    .ghost_x        (ghost_x),
    .ghost_y        (ghost_y),
    .busy           (busy),
    .map_rd_en      (map_rd_en),
    .map_addr       (map_addr),
    .map_rd_data    (map_rd_data),
    .map_wr_en      (map_wr_en),
    .map_wr_data    (map_wr_data),
    .collision_type (collision_type),
    .move_ack       (move_ack),
    .move_ok        (move_ok)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Map RAM with a one-cycle registered read.
  logic [1:0] mem [0:1023];
  logic [1:0] rd_q = '0;
  assign map_rd_data = rd_q;
  always @(posedge CLOCK_50) begin
    if (map_rd_en) rd_q <= mem[map_addr];
    if (map_wr_en) mem[map_addr] <= map_wr_data;
  end

  // Reference map, indexed by row then column.
  logic [1:0] ref_map [0:ROWS-1][0:COLS-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack = -100;
  int ack_cnt = 0;
  int pill_cnt = 0;
  logic prev_ct_nz = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: spacing of decisions, one-cycle codes, and a pill_counter stand-in.
  always @(negedge CLOCK_50) begin
    if (reset) begin
      cyc++;
      if (collision_type != 4'b0000)
        check("code_single_cycle", 32'(prev_ct_nz), 32'd0);
      if (move_ack) begin
        check("ack_gap", 32'((cyc - last_ack) >= 2), 32'd1);
        last_ack = cyc;
        ack_cnt++;
        if (collision_type == 4'b0010) pill_cnt++;
      end
      prev_ct_nz = (collision_type != 4'b0000);
    end else begin
      prev_ct_nz = 1'b0;
    end
  end

  task automatic set_ghost(input int i, input int x, input int y);
    ghost_x[i*5 +: 5] = 5'(x);
    ghost_y[i*5 +: 5] = 5'(y);
  endtask

  task automatic set_tile(input int x, input int y, input logic [1:0] t);
    ref_map[y][x] = t;
    mem[y*COLS + x] = t;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy !== 1'b0; k++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Expected outcome of a move from the game rules.
  task automatic predict(input int x, input int y, output logic [3:0] code, output logic clr);
    bit oor = (x >= COLS) || (y >= ROWS);
    bit hit = 1'b0;
    int t;
`ifdef GHOST_COLLIDE_EN
    for (int i = 0; i < 4; i++)
      if (int'(ghost_x[i*5 +: 5]) == x && int'(ghost_y[i*5 +: 5]) == y) hit = 1'b1;
`endif
    t = oor ? 1 : int'(ref_map[y][x]);
    if (hit)         code = 4'b1000;
    else if (t == 1) code = 4'b0001;
    else if (t == 3) code = 4'b0100;
    else if (t == 2) code = 4'b0010;
    else             code = 4'b0000;
    clr = !hit && (t >= 2);
  endtask

  task automatic do_move(input int x, input int y);
    logic [3:0] ecode;
    logic       eclr;
    bit         oor = (x >= COLS) || (y >= ROWS);
    int         addr = y * COLS + x;
    predict(x, y, ecode, eclr);
    wait_idle();
    move_valid = 1'b1;
    pac_x = 5'(x);
    pac_y = 5'(y);
    tick();
    move_valid = 1'b0;
    if (oor) begin
      check("oor_ack", 32'(move_ack), 32'd1);
      check("oor_code", 32'(collision_type), 32'(ecode));
      check("oor_ok", 32'(move_ok), 32'(ecode != 4'b0001));
      check("oor_no_read", 32'(map_rd_en), 32'd0);
      tick();
      check("oor_ack_drop", 32'(move_ack), 32'd0);
      check("oor_idle", 32'(busy), 32'd0);
    end else begin
      check("c1_rd_en", 32'(map_rd_en), 32'd1);
      check("c1_addr", 32'(map_addr), 32'(addr));
      check("c1_busy", 32'(busy), 32'd1);
      tick();
      check("c2_rd_off", 32'(map_rd_en), 32'd0);
      check("c2_no_ack", 32'(move_ack), 32'd0);
      tick();
      check("c3_ack", 32'(move_ack), 32'd1);
      check("c3_code", 32'(collision_type), 32'(ecode));
      check("c3_ok", 32'(move_ok), 32'(ecode != 4'b0001));
      tick();
      check("c4_wr_en", 32'(map_wr_en), 32'(eclr));
      check("c4_code_zero", 32'(collision_type), 32'd0);
      if (eclr) begin
        check("c4_wr_addr", 32'(map_addr), 32'(addr));
        check("c4_wr_data", 32'(map_wr_data), 32'd0);
        check("c4_busy", 32'(busy), 32'd1);
        tick();
        check("c5_wr_off", 32'(map_wr_en), 32'd0);
      end
      check("end_idle", 32'(busy), 32'd0);
      if (eclr) ref_map[y][x] = 2'b00;
      check("map_content", 32'(mem[addr]), 32'(ref_map[y][x]));
    end
  endtask

  initial begin
    int a0, p0, bx, by;
    logic prev_busy;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) set_tile(x, y, 2'($urandom_range(0, 3)));
    set_tile(1, 1, 2'b10);
    set_tile(2, 1, 2'b01);
    set_tile(3, 1, 2'b11);
    set_tile(4, 2, 2'b00);
    set_tile(12, 1, 2'b10);
    for (int i = 5; i < 9; i++) set_tile(i, 1, 2'b10);
    for (int i = 0; i < 4; i++) set_ghost(i, 31, 31);

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(map_rd_en), 32'd0);
    check("rst_wr_en", 32'(map_wr_en), 32'd0);
    check("rst_addr", 32'(map_addr), 32'd0);
    check("rst_wr_data", 32'(map_wr_data), 32'd0);
    check("rst_code", 32'(collision_type), 32'd0);
    check("rst_ack", 32'(move_ack), 32'd0);
    check("rst_ok", 32'(move_ok), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    tick();

    // Directed: pill at (1,1) is address 29, then wall, then out-of-range column
    do_move(1, 1);
    check("pill_erased_29", 32'(mem[29]), 32'd0);
    do_move(2, 1);
    do_move(COLS, 0);

    // Power pellet with ghost 2 on the same tile
    set_ghost(2, 3, 1);
    do_move(3, 1);
`ifdef GHOST_COLLIDE_EN
    check("ghost_power_kept", 32'(mem[1*COLS + 3]), 32'd3);
`else
    check("power_erased", 32'(mem[1*COLS + 3]), 32'd0);
`endif
    set_ghost(2, 31, 31);

    // Four pill moves with move_valid held high
    a0 = ack_cnt;
    p0 = pill_cnt;
    prev_busy = busy;
    move_valid = 1'b1;
    pac_x = 5'd5;
    pac_y = 5'd1;
    for (int n = 0, k = 0; n < 4 && k < 60; k++) begin
      tick();
      if (!prev_busy && busy) begin
        n++;
        pac_x = 5'(5 + n);
      end
      prev_busy = busy;
      if (n == 4) move_valid = 1'b0;
    end
    move_valid = 1'b0;
    wait_idle();
    check("b2b_acks", 32'(ack_cnt - a0), 32'd4);
    check("b2b_pill_count", 32'(pill_cnt - p0), 32'd4);
    for (int i = 5; i < 9; i++) check("b2b_erased", 32'(mem[1*COLS + i]), 32'd0);
    for (int i = 5; i < 9; i++) ref_map[1][i] = 2'b00;

    // Out-of-range requests held high: decisions every second cycle
    a0 = ack_cnt;
    move_valid = 1'b1;
    pac_x = 5'd28;
    pac_y = 5'd3;
    repeat (6) @(posedge CLOCK_50);
    #1;
    move_valid = 1'b0;
    wait_idle();
    check("oor_b2b_acks", 32'(ack_cnt - a0), 32'd3);

    // Request while busy is dropped
    a0 = ack_cnt;
    move_valid = 1'b1;
    pac_x = 5'd4;
    pac_y = 5'd2;
    tick();
    move_valid = 1'b0;
    tick();
    move_valid = 1'b1;
    pac_x = 5'd10;
    pac_y = 5'd10;
    tick();
    move_valid = 1'b0;
    repeat (8) tick();
    check("busy_ignored_acks", 32'(ack_cnt - a0), 32'd1);
    check("busy_ignored_map", 32'(mem[10*COLS + 10]), 32'(ref_map[10][10]));

    // Reset during WAIT
    a0 = ack_cnt;
    move_valid = 1'b1;
    pac_x = 5'd12;
    pac_y = 5'd1;
    tick();
    move_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(move_ack), 32'd0);
    tick();
    check("midrst_wr_en", 32'(map_wr_en), 32'd0);
    tick();
    @(negedge CLOCK_50);
    reset = 1'b1;
    tick();
    check("midrst_no_pulse", 32'(ack_cnt - a0), 32'd0);
    check("midrst_pill_kept", 32'(mem[1*COLS + 12]), 32'd2);

    // Random moves, ghosts sometimes parked on the target
    for (int r = 0; r < 40; r++) begin
      bx = $urandom_range(0, 31);
      by = $urandom_range(0, 31);
      for (int i = 0; i < 4; i++) set_ghost(i, $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) set_ghost($urandom_range(0, 3), bx, by);
      do_move(bx, by);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
